// File: rtl/dma_wr_req_arbiter_pkg.sv
// Shared constants and FSM encoding for the DMA write-request arbiter slice.
// Bus widths here mirror the project-wide type set used by the surrounding DMA logic.
package dma_wr_req_arbiter_pkg;

    localparam int VADDR_BITS    = 48;
    localparam int LEN_BITS      = 28;
    localparam int N_CHAN        = 4;
    localparam int AXI_DATA_BITS = 512;

    // Default sink-mux field widths for an N_CHAN / AXI_DATA_BITS configuration
    localparam int MUX_CHAN_BITS = $clog2(N_CHAN);
    localparam int MUX_BLEN_BITS = LEN_BITS - $clog2(AXI_DATA_BITS / 8);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dma_wr_req_arbiter_if.sv
// Sink-mux command channel: valid/ready handshake carrying channel, beat count minus one and last flag.
interface muxIntf #(
    parameter int CHAN_BITS = dma_wr_req_arbiter_pkg::MUX_CHAN_BITS,
    parameter int BLEN_W    = dma_wr_req_arbiter_pkg::MUX_BLEN_BITS
);
    typedef struct packed {
        logic [CHAN_BITS-1:0] chan;
        logic [BLEN_W-1:0]    len;
        logic                 last;
    } mux_data_t;

    logic      valid;
    logic      ready;
    mux_data_t data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/dma_wr_req_arbiter_rr.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping modulo N.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [N-1:0]        gnt,
    output logic [IDX_BITS-1:0] idx,
    output logic                any
);

    // Scan ptr+1 .. ptr+N; the pointer itself is examined last.
    always_comb begin
        int cand_v;
        gnt    = {N{1'b0}};
        idx    = {IDX_BITS{1'b0}};
        any    = 1'b0;
        cand_v = 0;
        for (int i = 1; i <= N; i++) begin
            cand_v = int'(ptr) + i;
            if (cand_v >= N) begin
                cand_v = cand_v - N;
            end else begin
                cand_v = cand_v;
            end
            if (!any && req[cand_v]) begin
                any         = 1'b1;
                gnt[cand_v] = 1'b1;
                idx         = IDX_BITS'(cand_v);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/dma_wr_req_arbiter.sv
// Arbitrates per-channel write requests into one DMA command plus a matching sink-mux command.
// Zero-length requests are accepted and dropped without issuing anything.
module dma_wr_req_arbiter
    import dma_wr_req_arbiter_pkg::*;
#(
    parameter int N_SPLIT_CHAN  = N_CHAN,
    parameter int MUX_DATA_BITS = AXI_DATA_BITS
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [N_SPLIT_CHAN-1:0]               req_valid,
    output logic [N_SPLIT_CHAN-1:0]               req_ready,
    input  logic [N_SPLIT_CHAN-1:0][VADDR_BITS-1:0] req_vaddr,
    input  logic [N_SPLIT_CHAN-1:0][LEN_BITS-1:0] req_len,
    input  logic [N_SPLIT_CHAN-1:0]               req_last,
    output logic                                  dma_valid,
    input  logic                                  dma_ready,
    output logic [VADDR_BITS-1:0]                 dma_vaddr,
    output logic [LEN_BITS-1:0]                   dma_len,
    output logic                                  dma_last,
    muxIntf.m                                     mux
);

    localparam int BEAT_BYTES        = MUX_DATA_BITS / 8;
    localparam int BEAT_LOG_BITS     = $clog2(BEAT_BYTES);
    localparam int BLEN_BITS         = LEN_BITS - BEAT_LOG_BITS;
    localparam int N_SPLIT_CHAN_BITS = $clog2(N_SPLIT_CHAN);

    // Beats minus one; the extra top bit keeps the round-up carry before shifting.
    function automatic logic [BLEN_BITS-1:0] beats_m1(input logic [LEN_BITS-1:0] len);
        logic [LEN_BITS:0] sum_v;
        logic [LEN_BITS:0] beats_v;
        sum_v   = {1'b0, len} + (LEN_BITS+1)'(BEAT_BYTES - 1);
        beats_v = (sum_v >> BEAT_LOG_BITS) - (LEN_BITS+1)'(1);
        return beats_v[BLEN_BITS-1:0];
    endfunction

    arb_state_t                   state_r, state_s;
    logic                         dma_pend_r, dma_pend_s;
    logic                         mux_pend_r, mux_pend_s;
    logic [N_SPLIT_CHAN_BITS-1:0] rr_ptr_r;
    logic                         grant_s;
    logic [N_SPLIT_CHAN-1:0]      gnt_s;
    logic [N_SPLIT_CHAN_BITS-1:0] gnt_idx_s;
    logic                         gnt_any_s;
    logic [VADDR_BITS-1:0]        vaddr_r;
    logic [LEN_BITS-1:0]          len_r;
    logic                         last_r;
    logic [N_SPLIT_CHAN_BITS-1:0] chan_r;
    logic [BLEN_BITS-1:0]         blen_r;

    rr_arbiter_n #(
        .N        (N_SPLIT_CHAN),
        .IDX_BITS (N_SPLIT_CHAN_BITS)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .gnt (gnt_s),
        .idx (gnt_idx_s),
        .any (gnt_any_s)
    );

    // Next-state, pend flags and request accept.
    always_comb begin
        state_s    = state_r;
        dma_pend_s = dma_pend_r;
        mux_pend_s = mux_pend_r;
        grant_s    = 1'b0;
        req_ready  = {N_SPLIT_CHAN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (aresetn && gnt_any_s) begin
                    grant_s   = 1'b1;
                    req_ready = gnt_s;
                    if (req_len[gnt_idx_s] != {LEN_BITS{1'b0}}) begin
                        dma_pend_s = 1'b1;
                        mux_pend_s = 1'b1;
                        state_s    = ST_ISSUE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (dma_pend_r && dma_ready) begin
                    dma_pend_s = 1'b0;
                end else begin
                    dma_pend_s = dma_pend_r;
                end
                if (mux_pend_r && mux.ready) begin
                    mux_pend_s = 1'b0;
                end else begin
                    mux_pend_s = mux_pend_r;
                end
                // Both sides done: the following cycle is already back in idle.
                if (!dma_pend_s && !mux_pend_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                dma_pend_s = 1'b0;
                mux_pend_s = 1'b0;
            end
        endcase
    end

    // Control state; channel 0 gets first priority out of reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r    <= ST_IDLE;
            dma_pend_r <= 1'b0;
            mux_pend_r <= 1'b0;
            rr_ptr_r   <= N_SPLIT_CHAN_BITS'(N_SPLIT_CHAN - 1);
        end else begin
            state_r    <= state_s;
            dma_pend_r <= dma_pend_s;
            mux_pend_r <= mux_pend_s;
            if (grant_s) begin
                rr_ptr_r <= gnt_idx_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Payload capture at grant; contents are meaningless while no valid is raised.
    always_ff @(posedge aclk) begin
        if (grant_s) begin
            vaddr_r <= req_vaddr[gnt_idx_s];
            len_r   <= req_len[gnt_idx_s];
            last_r  <= req_last[gnt_idx_s];
            chan_r  <= gnt_idx_s;
            blen_r  <= beats_m1(req_len[gnt_idx_s]);
        end else begin
            vaddr_r <= vaddr_r;
            len_r   <= len_r;
            last_r  <= last_r;
            chan_r  <= chan_r;
            blen_r  <= blen_r;
        end
    end

    assign dma_valid     = dma_pend_r;
    assign dma_vaddr     = vaddr_r;
    assign dma_len       = len_r;
    assign dma_last      = last_r;
    assign mux.valid     = mux_pend_r;
    assign mux.data.chan = chan_r;
    assign mux.data.len  = blen_r;
    assign mux.data.last = last_r;

endmodule

// File: tb/tb_dma_wr_req_arbiter.sv
// Directed bench for dma_wr_req_arbiter: a table of single-request vectors plus
// hand-written sequences for round-robin order, back-pressure, zero length and mid-issue reset.
module tb_dma_wr_req_arbiter;
    import dma_wr_req_arbiter_pkg::*;

    localparam int NC  = 4;
    localparam int BLW = 22;

    logic                           aclk = 1'b0;
    logic                           aresetn;
    logic [NC-1:0]                  req_valid;
    logic [NC-1:0]                  req_ready;
    logic [NC-1:0][VADDR_BITS-1:0]  req_vaddr;
    logic [NC-1:0][LEN_BITS-1:0]    req_len;
    logic [NC-1:0]                  req_last;
    logic                           dma_valid;
    logic                           dma_ready;
    logic [VADDR_BITS-1:0]          dma_vaddr;
    logic [LEN_BITS-1:0]            dma_len;
    logic                           dma_last;

    muxIntf #(.CHAN_BITS(2), .BLEN_W(BLW)) mux_if ();

    dma_wr_req_arbiter #(.N_SPLIT_CHAN(NC), .MUX_DATA_BITS(512)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vaddr (req_vaddr),
        .req_len   (req_len),
        .req_last  (req_last),
        .dma_valid (dma_valid),
        .dma_ready (dma_ready),
        .dma_vaddr (dma_vaddr),
        .dma_len   (dma_len),
        .dma_last  (dma_last),
        .mux       (mux_if.m)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                    ch;
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic                  last;
        logic [BLW-1:0]        exp_blen;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < NC; i++) begin
            req_vaddr[i] = '0;
            req_len[i]   = '0;
        end
    endtask

    task automatic set_req(input int ch, input logic [VADDR_BITS-1:0] va,
                           input logic [LEN_BITS-1:0] len, input logic last);
        req_valid[ch] = 1'b1;
        req_vaddr[ch] = va;
        req_len[ch]   = len;
        req_last[ch]  = last;
    endtask

    initial begin
        vecs[0] = '{2, 48'h1000, 28'd4096, 1'b1, 22'd63};
        vecs[1] = '{0, 48'h2000, 28'd65,   1'b0, 22'd1};
        vecs[2] = '{1, 48'h3040, 28'd64,   1'b1, 22'd0};
        vecs[3] = '{3, 48'h0040, 28'd1,    1'b0, 22'd0};
        vecs[4] = '{1, 48'h5000, 28'd128,  1'b0, 22'd1};
        vecs[5] = '{0, 48'h6000, 28'd4095, 1'b1, 22'd63};
        vecs[6] = '{3, 48'h7000, 28'hFFFFFFF, 1'b1, 22'h3FFFFF};

        aresetn      = 1'b0;
        dma_ready    = 1'b0;
        mux_if.ready = 1'b0;
        clear_req();
        req_valid = 4'hF;
        step();
        step();
        chk("reset_dma_valid", 64'(dma_valid), 64'd0);
        chk("reset_mux_valid", 64'(mux_if.valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        clear_req();
        aresetn = 1'b1;

        // All channels valid continuously: rotation starting at channel 0
        for (int i = 0; i < NC; i++) set_req(i, 48'(32'h100 * (i + 1)), 28'd64, 1'b0);
        dma_ready    = 1'b1;
        mux_if.ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % NC)));
            step();
            chk("rr_issue_ready", 64'(req_ready), 64'd0);
            chk("rr_issue_chan", 64'(mux_if.data.chan), 64'(k % NC));
            chk("rr_issue_vaddr", 64'(dma_vaddr), 64'(32'h100 * ((k % NC) + 1)));
            step();
        end
        clear_req();

        // Table of single requests with both sinks ready
        for (int v = 0; v < 7; v++) begin
            clear_req();
            set_req(vecs[v].ch, vecs[v].vaddr, vecs[v].len, vecs[v].last);
            #1;
            chk("vec_grant", 64'(req_ready), 64'(4'b0001 << vecs[v].ch));
            step();
            clear_req();
            chk("vec_dma_valid", 64'(dma_valid), 64'd1);
            chk("vec_dma_vaddr", 64'(dma_vaddr), 64'(vecs[v].vaddr));
            chk("vec_dma_len", 64'(dma_len), 64'(vecs[v].len));
            chk("vec_dma_last", 64'(dma_last), 64'(vecs[v].last));
            chk("vec_mux_valid", 64'(mux_if.valid), 64'd1);
            chk("vec_mux_chan", 64'(mux_if.data.chan), 64'(vecs[v].ch));
            chk("vec_mux_len", 64'(mux_if.data.len), 64'(vecs[v].exp_blen));
            chk("vec_mux_last", 64'(mux_if.data.last), 64'(vecs[v].last));
            step();
            chk("vec_done_dma", 64'(dma_valid), 64'd0);
            chk("vec_done_mux", 64'(mux_if.valid), 64'd0);
        end

        // Mux back-pressure: DMA side completes first, mux held for five cycles
        clear_req();
        set_req(0, 48'h8000, 28'd256, 1'b1);
        dma_ready    = 1'b1;
        mux_if.ready = 1'b0;
        #1;
        chk("bp_grant", 64'(req_ready), 64'b0001);
        step();
        clear_req();
        set_req(1, 48'h9100, 28'd128, 1'b0);
        #1;
        chk("bp_dma_valid", 64'(dma_valid), 64'd1);
        chk("bp_mux_valid", 64'(mux_if.valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_dma_done", 64'(dma_valid), 64'd0);
            chk("bp_mux_held", 64'(mux_if.valid), 64'd1);
            chk("bp_mux_len", 64'(mux_if.data.len), 64'd3);
            chk("bp_mux_chan", 64'(mux_if.data.chan), 64'd0);
            chk("bp_no_grant", 64'(req_ready), 64'd0);
        end
        mux_if.ready = 1'b1;
        #1;
        chk("bp_hs_no_grant", 64'(req_ready), 64'd0);
        step();
        chk("bp_after_mux_valid", 64'(mux_if.valid), 64'd0);
        chk("bp_next_grant", 64'(req_ready), 64'b0010);
        step();
        clear_req();
        chk("bp_next_chan", 64'(mux_if.data.chan), 64'd1);
        chk("bp_next_len", 64'(mux_if.data.len), 64'd1);
        step();

        // Zero-length request on ch1 consumed silently, ch3 follows
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        clear_req();
        set_req(1, 48'h9000, 28'd0, 1'b1);
        set_req(3, 48'hA000, 28'd128, 1'b0);
        #1;
        chk("zl_grant_ch1", 64'(req_ready), 64'b0010);
        step();
        req_valid[1] = 1'b0;
        #1;
        chk("zl_no_dma", 64'(dma_valid), 64'd0);
        chk("zl_no_mux", 64'(mux_if.valid), 64'd0);
        chk("zl_grant_ch3", 64'(req_ready), 64'b1000);
        step();
        clear_req();
        chk("zl_dma_valid", 64'(dma_valid), 64'd1);
        chk("zl_dma_vaddr", 64'(dma_vaddr), 64'hA000);
        chk("zl_dma_len", 64'(dma_len), 64'd128);
        chk("zl_mux_chan", 64'(mux_if.data.chan), 64'd3);
        chk("zl_mux_len", 64'(mux_if.data.len), 64'd1);
        step();

        // Reset while both commands are pending
        clear_req();
        set_req(2, 48'hB000, 28'd64, 1'b1);
        dma_ready    = 1'b0;
        mux_if.ready = 1'b0;
        #1;
        chk("rst_grant_ch2", 64'(req_ready), 64'b0100);
        step();
        clear_req();
        chk("rst_pre_dma", 64'(dma_valid), 64'd1);
        chk("rst_pre_mux", 64'(mux_if.valid), 64'd1);
        aresetn = 1'b0;
        step();
        chk("rst_dma_dropped", 64'(dma_valid), 64'd0);
        chk("rst_mux_dropped", 64'(mux_if.valid), 64'd0);
        aresetn = 1'b1;
        set_req(0, 48'hC000, 28'd64, 1'b0);
        set_req(2, 48'hD000, 28'd64, 1'b0);
        #1;
        chk("rst_next_grant", 64'(req_ready), 64'b0001);
        step();
        clear_req();
        chk("rst_next_vaddr", 64'(dma_vaddr), 64'hC000);
        dma_ready    = 1'b1;
        mux_if.ready = 1'b1;
        step();
        step();
        chk("rst_final_idle", 64'(dma_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_wr_req_arbiter.md
DMA_WR_REQ_ARBITER -- requirements
Module: dma_wr_req_arbiter

Interface
REQ-001 Parameter N_SPLIT_CHAN, default N_CHAN, number of requesting channels (>=2).
REQ-002 Parameter MUX_DATA_BITS, default AXI_DATA_BITS, width of the data path the sink mux forwards.
REQ-003 aclk  in  1  clock; every register is updated on the rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  N_SPLIT_CHAN  per-channel write-request valid.
REQ-006 req_ready  out  N_SPLIT_CHAN  per-channel request accept.
REQ-007 req_vaddr  in  N_SPLIT_CHAN x VADDR_BITS  per-channel target address.
REQ-008 req_len  in  N_SPLIT_CHAN x LEN_BITS  per-channel transfer length in bytes.
REQ-009 req_last  in  N_SPLIT_CHAN  per-channel last-of-transaction flag.
REQ-010 dma_valid / dma_ready  out / in  1 / 1  DMA command handshake.
REQ-011 dma_vaddr, dma_len, dma_last  out  VADDR_BITS, LEN_BITS, 1  DMA command payload.
REQ-012 mux  muxIntf.m  master side of the sink-mux command: valid, ready, data.chan (N_SPLIT_CHAN_BITS), data.len (BLEN_BITS), data.last.

Function
REQ-013 FSM states: ST_IDLE, ST_ISSUE.
REQ-014 ST_IDLE: grant the first valid channel, scanning round-robin from rr_ptr+1 modulo N_SPLIT_CHAN.
REQ-015 Only the winner has req_ready high, in the same cycle as the grant; all other req_ready are 0; all req_ready are 0 in ST_ISSUE.
REQ-016 On grant, latch vaddr, len, last and chan into registers and set rr_ptr to the winner.
REQ-017 If the granted len is nonzero, set dma_pend=1 and mux_pend=1 and enter ST_ISSUE.
REQ-018 If the granted len is 0, consume and discard the request, update rr_ptr, stay in ST_IDLE, and emit no command.
REQ-019 ST_ISSUE: dma_valid=dma_pend and mux.valid=mux_pend, with payloads driven from the registers only.
REQ-020 Each pend flag clears independently on its own valid&ready; the two handshakes may complete in any order or in the same cycle.
REQ-021 Leave ST_ISSUE for ST_IDLE in the cycle after both pend flags are clear; a same-cycle completion of both returns the next cycle.
REQ-022 mux.data.len = ceil(len / (MUX_DATA_BITS/8)) - 1, computed as ((len + BEAT_BYTES-1) >> BEAT_LOG_BITS) - 1 and truncated to BLEN_BITS; the carry into LEN_BITS+1 is kept before the shift.
REQ-023 mux.data.chan = granted index; mux.data.last = dma_last = latched req_last.
REQ-024 Every output is driven from a register or a state decode, with no combinational path from dma_ready or mux.ready to any valid.
REQ-025 Peak throughput is one request per 2 cycles; payloads stay stable while valid is high and ready is low.
REQ-026 A channel whose req_valid drops before it is granted is skipped with no effect.

Reset
REQ-027 On aresetn=0: state=ST_IDLE, dma_pend=0, mux_pend=0, rr_ptr=N_SPLIT_CHAN-1 (channel 0 has first priority), req_ready=0, dma_valid=0, mux.valid=0.
REQ-028 Latched payload registers are not reset; their value is don't-care while the valids are low.
REQ-029 Reset during ST_ISSUE drops the pending command(s); nothing is reissued after release.

Structure
REQ-030 VADDR_BITS, LEN_BITS, N_CHAN, AXI_DATA_BITS and the muxIntf/mux data typedef reside in lynxTypes; BEAT_LOG_BITS, BLEN_BITS and N_SPLIT_CHAN_BITS are local constants.
REQ-031 The round-robin grant is a sub-module, rr_arbiter_n (request vector plus pointer in, one-hot grant plus index out, purely combinational); the rest is flat.

Verification (N_SPLIT_CHAN=4, MUX_DATA_BITS=512, so 64-B beats)
REQ-032 ch2 req len=4096, vaddr=0x1000, last=1, both readies high -> one dma cmd (0x1000, 4096, 1) and one mux cmd chan=2, len=63, last=1.
REQ-033 len=65 -> mux len=1; len=64 -> mux len=0; len=1 -> mux len=0.
REQ-034 All four channels valid continuously after reset -> grant order 0,1,2,3,0; exactly one req_ready high at a time.
REQ-035 dma_ready=1, mux.ready=0 for 5 cycles then 1 -> one DMA handshake, mux.valid held with stable payload, no new grant until the cycle after the mux handshake.
REQ-036 ch1 len=0 with ch3 valid -> ch1 consumed with no command; next cycle ch3 granted and issued normally.
REQ-037 aresetn pulsed low during ST_ISSUE with both pends set -> both valids low the next cycle, rr_ptr=3, and the next grant goes to channel 0.
